// File: rtl/aes_inv_cipher.sv
// Iterative AES inverse cipher (FIPS-197 decryption), key size set by NK/NR.
// One round per clock: capture, initial AddRoundKey, NR-1 full rounds, final round.
// Ports:
//   i_clk, i_rst_n       clock, asynchronous active-low reset
//   i_start              decrypt request, taken only while o_busy is low
//   i_data  [127:0]      ciphertext, byte 0 in bits [127:120]
//   i_key   [32*NK-1:0]  cipher key, key byte 0 in the top byte
//   o_data  [127:0]      plaintext, updated only on completion
//   o_valid              one-cycle completion pulse
//   o_busy               high while a block is in progress
module aes_inv_cipher #(
  parameter int unsigned NK = 4,
  parameter int unsigned NR = 10
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [127:0]      i_data,
  input  logic [32*NK-1:0]  i_key,
  output logic [127:0]      o_data,
  output logic              o_valid,
  output logic              o_busy
);

  localparam int unsigned NW = 4 * (NR + 1);
  localparam int unsigned RW = 4;

  // GF(2^8) multiply by x, polynomial 0x11b
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (maps 0 to 0)
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] p;
    logic [7:0] s;
    p = 8'h01;
    s = a;
    for (int i = 1; i < 8; i++) begin
      s = gf_mul(s, s);
      p = gf_mul(p, s);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] v;
    v = gf_inv(a);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    return gf_inv({a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] v);
    return {sbox(v[31:24]), sbox(v[23:16]), sbox(v[15:8]), sbox(v[7:0])};
  endfunction

  // Full key schedule, word 0 in the top 32 bits
  function automatic logic [32*NW-1:0] expand_key(input logic [32*NK-1:0] k);
    logic [31:0]      wk [NW];
    logic [31:0]      t;
    logic [7:0]       rc;
    logic [32*NW-1:0] res;
    rc  = 8'h01;
    res = '0;
    for (int i = 0; i < NW; i++) begin
      if (i < NK) begin
        wk[i] = k[32*(NK-i)-1 -: 32];
      end else begin
        t = wk[i-1];
        if (i % NK == 0) begin
          t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
          rc = xtime(rc);
        end else if (NK > 6 && i % NK == 4) begin
          t = sub_word(t);
        end
        wk[i] = wk[i-NK] ^ t;
      end
      res[32*(NW-i)-1 -: 32] = wk[i];
    end
    return res;
  endfunction

  // Row n rotated right by n: new column c takes old column c-n
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+4-r)%4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    for (int k = 0; k < 16; k++) o[127-8*k -: 8] = inv_sbox(s[127-8*k -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
      o[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
      o[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
      o[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
    end
    return o;
  endfunction

  typedef enum logic [1:0] {S_IDLE, S_INIT, S_ROUND} fsm_t;

  fsm_t             fsm_q;
  logic [RW-1:0]    rnd_q;
  logic [127:0]     st_q;
  logic [32*NK-1:0] key_q;
  logic [32*NW-1:0] w_all;
  logic [127:0]     rk;
  logic [127:0]     sub_add;
  logic [127:0]     rnd_out;

  // Round datapath; rnd_q selects the round key and whether MixColumns applies
  always_comb begin
    w_all   = expand_key(key_q);
    rk      = w_all[32*NW-1-128*int'(rnd_q) -: 128];
    sub_add = inv_sub_bytes(inv_shift_rows(st_q)) ^ rk;
    rnd_out = (rnd_q == '0) ? sub_add : inv_mix_columns(sub_add);
  end

  // Sequencer: capture, initial key add (rnd_q = NR), then rounds NR-1 .. 0
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      fsm_q   <= S_IDLE;
      rnd_q   <= '0;
      st_q    <= '0;
      key_q   <= '0;
      o_data  <= '0;
      o_valid <= 1'b0;
      o_busy  <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      case (fsm_q)
        S_IDLE: begin
          if (i_start) begin
            st_q   <= i_data;
            key_q  <= i_key;
            rnd_q  <= RW'(NR);
            o_busy <= 1'b1;
            fsm_q  <= S_INIT;
          end
        end
        S_INIT: begin
          st_q  <= st_q ^ rk;
          rnd_q <= rnd_q - RW'(1);
          fsm_q <= S_ROUND;
        end
        S_ROUND: begin
          if (rnd_q == '0) begin
            o_data  <= rnd_out;
            o_valid <= 1'b1;
            o_busy  <= 1'b0;
            fsm_q   <= S_IDLE;
          end else begin
            st_q  <= rnd_out;
            rnd_q <= rnd_q - RW'(1);
          end
        end
        default: fsm_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_inv_cipher.sv
// Bench for aes_inv_cipher: one instance per key size (NK=4/6/8).
// Reference is a forward AES encryptor built from a generated S-box; random
// plaintexts are encrypted by it and the DUT must recover them.
module tb_aes_inv_cipher;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start [3];
  logic [127:0] din   [3];
  logic [255:0] kin   [3];
  logic [127:0] dout  [3];
  logic         vld   [3];
  logic         bsy   [3];

  int errors = 0;
  int checks = 0;
  int vcnt [3] = '{0, 0, 0};
  logic [7:0] sb [256];

  always #5 clk = ~clk;

  aes_inv_cipher #(.NK(4), .NR(10)) u_dut4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start[0]), .i_data(din[0]),
    .i_key(kin[0][255:128]), .o_data(dout[0]), .o_valid(vld[0]), .o_busy(bsy[0]));

  aes_inv_cipher #(.NK(6), .NR(12)) u_dut6 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start[1]), .i_data(din[1]),
    .i_key(kin[1][255:64]), .o_data(dout[1]), .o_valid(vld[1]), .o_busy(bsy[1]));

  aes_inv_cipher #(.NK(8), .NR(14)) u_dut8 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start[2]), .i_data(din[2]),
    .i_key(kin[2]), .o_data(dout[2]), .o_valid(vld[2]), .o_busy(bsy[2]));

  // Count o_valid pulses per instance
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) if (vld[i] === 1'b1) vcnt[i] <= vcnt[i] + 1;
  end

  // ---------------- reference model ----------------
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // S-box by walking generator 3 and its inverse 0xf6 in lockstep
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sb[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sb[0] = 8'h63;
  endtask

  function automatic logic [31:0] subw(input logic [31:0] v);
    return {sb[v[31:24]], sb[v[23:16]], sb[v[15:8]], sb[v[7:0]]};
  endfunction

  function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [255:0] key, input int nk);
    logic [31:0]  w [60];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   rc, a0, a1, a2, a3;
    logic [31:0]  tmp;
    logic [127:0] res;
    int nr;
    nr = nk + 6;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      tmp = w[i-1];
      if (i % nk == 0) begin
        tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
        rc  = xt(rc);
      end else if (nk > 6 && i % nk == 4) begin
        tmp = subw(tmp);
      end
      w[i] = w[i-nk] ^ tmp;
    end
    for (int k = 0; k < 16; k++) s[k] = pt[127-8*k -: 8] ^ w[k/4][31-8*(k%4) -: 8];
    for (int r = 1; r <= nr; r++) begin
      for (int k = 0; k < 16; k++) t[k] = sb[s[k]];
      for (int rr = 0; rr < 4; rr++)
        for (int c = 0; c < 4; c++) s[rr+4*c] = t[rr+4*((c+rr)%4)];
      if (r < nr) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      end
      for (int k = 0; k < 16; k++) s[k] = s[k] ^ w[4*r+k/4][31-8*(k%4) -: 8];
    end
    for (int k = 0; k < 16; k++) res[127-8*k -: 8] = s[k];
    return res;
  endfunction

  // ---------------- helpers ----------------
  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Call at a negedge: start is taken on the next posedge, then inputs are scrambled
  task automatic do_start(input int idx, input logic [255:0] k, input logic [127:0] c);
    start[idx] = 1'b1;
    din[idx]   = c;
    kin[idx]   = k;
    @(negedge clk);
    start[idx] = 1'b0;
    din[idx]   = rnd128();
    kin[idx]   = {rnd128(), rnd128()};
  endtask

  task automatic wait_valid(input int idx, output int n);
    n = 0;
    while (vld[idx] !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic run(input int idx, input logic [255:0] k, input logic [127:0] c,
                     input logic [127:0] exp, input string tag);
    int n;
    do_start(idx, k, c);
    wait_valid(idx, n);
    chk({tag, " data"}, dout[idx], exp);
    chk({tag, " latency"}, 128'(n), 128'(11 + 2*idx));
  endtask

  // ---------------- stimulus ----------------
  localparam logic [255:0] KEY_C4 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] KEY_C6 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
  localparam logic [255:0] KEY_C8 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [255:0] KEY_B  = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [127:0] CT_C4  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT_C6  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT_C8  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] PT_C   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;

  initial begin
    int n, n2, v0;
    logic [255:0] key;
    logic [127:0] pt, ct;

    build_sbox();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      start[i] = 1'b0;
      din[i]   = '0;
      kin[i]   = '0;
    end

    // Reset values
    #12;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset o_data[%0d]", i), dout[i], 128'h0);
      chk($sformatf("reset o_valid[%0d]", i), 128'(vld[i]), 128'h0);
      chk($sformatf("reset o_busy[%0d]", i), 128'(bsy[i]), 128'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Known-answer vectors for each key size
    run(0, KEY_C4, CT_C4, PT_C, "kat nk4");
    run(1, KEY_C6, CT_C6, PT_C, "kat nk6");
    run(2, KEY_C8, CT_C8, PT_C, "kat nk8");

    // Start while busy is ignored
    @(negedge clk);
    v0 = vcnt[0];
    do_start(0, KEY_B, CT_B);
    repeat (3) @(negedge clk);
    start[0] = 1'b1;
    din[0]   = rnd128();
    kin[0]   = {rnd128(), rnd128()};
    @(negedge clk);
    start[0] = 1'b0;
    wait_valid(0, n);
    chk("busy-start data", dout[0], PT_B);
    chk("busy-start latency", 128'(n + 4), 128'(11));
    repeat (20) @(negedge clk);
    chk("busy-start valid count", 128'(vcnt[0] - v0), 128'(1));
    chk("busy-start idle", 128'(bsy[0]), 128'h0);

    // Reset mid-operation aborts; a start at release is taken
    v0 = vcnt[0];
    do_start(0, KEY_C4, CT_C4);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort o_data", dout[0], 128'h0);
    chk("abort o_valid", 128'(vld[0]), 128'h0);
    chk("abort o_busy", 128'(bsy[0]), 128'h0);
    @(negedge clk);
    rst_n = 1'b1;
    run(0, KEY_C4, CT_C4, PT_C, "post-reset");
    repeat (4) @(negedge clk);
    chk("abort valid count", 128'(vcnt[0] - v0), 128'(1));

    // Back-to-back: new start in the o_valid cycle
    do_start(0, KEY_C4, CT_C4);
    wait_valid(0, n);
    chk("b2b first data", dout[0], PT_C);
    chk("b2b first latency", 128'(n), 128'(11));
    do_start(0, KEY_B, CT_B);
    wait_valid(0, n2);
    chk("b2b second data", dout[0], PT_B);
    chk("b2b spacing", 128'(n2 + 1), 128'(12));

    // Random blocks against the forward reference
    for (int idx = 0; idx < 3; idx++) begin
      for (int j = 0; j < 4; j++) begin
        @(negedge clk);
        key = {rnd128(), rnd128()};
        pt  = rnd128();
        ct  = aes_enc(pt, key, 4 + 2*idx);
        run(idx, key, ct, pt, $sformatf("rand nk%0d #%0d", 4 + 2*idx, j));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/aes_inv_cipher.md
# aes_inv_cipher

Iterative AES inverse cipher (FIPS-197 decryption) for 128-, 192- and 256-bit keys, selected by parameter. It accepts one 128-bit ciphertext block and a cipher key, expands the key schedule internally, and produces the 128-bit plaintext after a fixed number of clock cycles. It sits in the decryption datapath as a self-contained block. The matching encryption block is a separate module.

## Interface
- `NK`, default 4: key length in 32-bit words; legal values are 4, 6 and 8.
- `NR`, default 10: number of rounds; must equal NK+6 (10, 12 or 14).
- `i_clk`  input  1  sole clock; all state changes on the rising edge.
- `i_rst_n`  input  1  reset, asynchronous and active-low.
- `i_start`  input  1  request to decrypt the block on `i_data` with key `i_key`.
- `i_data`  input  128  ciphertext block; `i_data[127:120]` is byte 0.
- `i_key`  input  32*NK  cipher key; the top byte is key byte 0.
- `o_data`  output  128  plaintext block, same byte order as `i_data`.
- `o_valid`  output  1  one-cycle pulse: `o_data` holds a new result.
- `o_busy`  output  1  high while a block is in progress.

## Operation
- Byte order:
  - State bytes map column-major as in FIPS-197: byte k goes to row k%4, column k/4.
  - Key words map the same way: w[0] = `i_key[32*NK-1 -: 32]`.
- Key expansion follows standard FIPS-197 and produces 4*(NR+1) words:
  - For i%NK==0: RotWord, then SubWord, then XOR with Rcon[i/NK].
  - For NK=8 and i%8==4: SubWord only.
  - Key expansion is computed combinationally from the registered key.
  - Round key r is words 4r..4r+3.
- Sequence after a start is accepted:
  - Capture edge: register `i_data` and `i_key`, and set round counter = NR.
  - Initial step: state ^= rk[NR].
  - Rounds r = NR-1 down to 1: state = InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ rk[r]).
  - Final round r=0: state = InvSubBytes(InvShiftRows(state)) ^ rk[0]. No InvMixColumns.
- Operator definitions:
  - InvShiftRows rotates row n right by n bytes.
  - InvSubBytes uses the FIPS-197 inverse S-box.
  - The forward S-box is also required, for key expansion.
  - InvMixColumns multiplies each column by {0e,0b,0d,09} in GF(2^8) with polynomial 0x11b.
- Start handshake:
  - `i_start` is accepted only when `o_busy`=0.
  - `i_start` while busy is ignored; the block in progress is not disturbed.
- `o_data` updates only at completion and holds its value until the next completion.
- The internal state register is not visible on `o_data` during rounds.

## Timing
- Reset (`i_rst_n`=0, asynchronous): `o_data`=0, `o_valid`=0, `o_busy`=0, round counter=0.
  - An operation in flight is aborted with no `o_valid`.
  - The block accepts a new start on the first edge after reset is released.
- Let E0 be the edge at which `i_start` is accepted:
  - `o_busy` rises after E0.
  - The initial AddRoundKey happens at E1.
  - Rounds NR-1..1 happen at E2..E_NR.
  - The final round happens at E_{NR+1}.
- After E_{NR+1}:
  - `o_valid`=1 for exactly one cycle.
  - `o_data` = plaintext.
  - `o_busy`=0 in the same cycle.
- Latency from accept edge to `o_valid` high is NR+1 cycles: 11, 13 or 15.
- A new `i_start` in the `o_valid` cycle is accepted (busy=0).
  - Back-to-back throughput is one block per NR+2 cycles.
- `i_data` and `i_key` need to be stable only at the accepting edge.

## Test plan
- NK=4, NR=10: key 000102030405060708090a0b0c0d0e0f, ct 69c4e0d86a7b0430d8cdb78070b4c55a -> `o_data` 00112233445566778899aabbccddeeff, `o_valid` 11 cycles after accept.
- NK=6, NR=12: key 000102030405060708090a0b0c0d0e0f1011121314151617, ct dda97ca4864cdfe06eaf70a0ec0d7191 -> 00112233445566778899aabbccddeeff, latency 13.
- NK=8, NR=14: key 000102…1e1f, ct 8ea2b7ca516745bfeafc49904b496089 -> 00112233445566778899aabbccddeeff, latency 15.
- NK=4: key 2b7e151628aed2a6abf7158809cf4f3c, ct 3925841d02dc09fbdc118597196a0b32 -> 3243f6a8885a308d313198a2e0370734. Then pulse `i_start` with different data mid-operation -> ignored; first result unchanged and exactly one `o_valid`.
- Assert `i_rst_n`=0 at round 5, then release -> outputs 0 immediately and no `o_valid`. A fresh start then decrypts the C.1 vector correctly.
- Back-to-back: C.1 vector, then `i_start` in the `o_valid` cycle with the Appendix B vector -> both plaintexts correct, with `o_valid` pulses 12 cycles apart.
